// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: default payload widths, the beat record and an
// occupancy helper used by the skid stage.
package pipe_skid_stage_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned CTRL_W_DEF = 4;
   localparam int unsigned OCC_W      = 2;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [CTRL_W_DEF-1:0] ctrl;
   } beat_t;

   function automatic logic [OCC_W-1:0] occ_count(input logic a, input logic b);
      return OCC_W'(a) + OCC_W'(b);
   endfunction

endpackage

// File: rtl/pipe_skid_stage_entry_reg.sv
// One pipeline entry: valid flag plus payload. Clear wins over load, and the
// payload is kept on clear so the head data holds its last value.
module pipe_entry_reg
   import pipe_skid_stage_pkg::*;
#(
   parameter int unsigned W = DATA_W_DEF + CTRL_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] d_i,
   output logic         valid_o,
   output logic [W-1:0] q_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign q_o     = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage (main head + skid) with stall/flush control and a
// saturating count of flushes that discarded held beats.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [OCC_W-1:0]  occupancy_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int unsigned BEAT_W = DATA_W + CTRL_W;

   logic              main_v, skid_v;
   logic [BEAT_W-1:0] main_q, skid_q, main_d, in_beat;
   logic              push, pop, flush_eff;
   logic              main_load, main_clr, skid_load, skid_clr;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   assign in_beat = {in_data_i, in_ctrl_i};

   // Handshakes only look at registered valids and stall, never out_ready_i for in_ready_o.
   always_comb begin
      flush_eff   = flush_i && !stall_i;
      in_ready_o  = !skid_v && !stall_i;
      out_valid_o = main_v && !stall_i;
      push        = in_valid_i && in_ready_o && !flush_i;
      pop         = out_valid_o && out_ready_i && !flush_i;

      main_d      = (pop && skid_v) ? skid_q : in_beat;
      main_clr    = flush_eff || (pop && !skid_v && !push);
      main_load   = (pop && (skid_v || push)) || (push && !main_v);
      skid_clr    = flush_eff || (pop && skid_v);
      skid_load   = push && main_v && !pop;

      flush_cnt_d = flush_cnt_q;
      if (flush_eff && (main_v || skid_v) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         flush_cnt_q <= '0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
      end
   end

   pipe_entry_reg #(.W(BEAT_W)) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (main_load),
      .clear_i (main_clr),
      .d_i     (main_d),
      .valid_o (main_v),
      .q_o     (main_q)
   );

   pipe_entry_reg #(.W(BEAT_W)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .d_i     (in_beat),
      .valid_o (skid_v),
      .q_o     (skid_q)
   );

   assign out_data_o  = main_q[BEAT_W-1 -: DATA_W];
   assign out_ctrl_o  = out_valid_o ? main_q[CTRL_W-1:0] : '0;
   assign occupancy_o = occ_count(main_v, skid_v);
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a queue-based model predicts handshakes,
// occupancy and the flush count; a monitor compares every beat leaving the stage.
module tb_pipe_skid_stage;
   import pipe_skid_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        flush_i, stall_i, in_valid_i, out_ready_i;
   logic [31:0] in_data_i;
   logic [3:0]  in_ctrl_i;
   logic        in_ready_o, out_valid_o;
   logic [31:0] out_data_o;
   logic [3:0]  out_ctrl_o;
   logic [1:0]  occupancy_o;
   logic [15:0] flush_cnt_o;

   logic        s_flush, s_valid;
   logic [31:0] s_data;
   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_data;
   logic [3:0]  s_out_ctrl;
   logic [1:0]  s_occ;
   logic [1:0]  s_fcnt;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   beat_t mon_e;
   int    mdl_occ = 0;
   int    exp_fcnt = 0;
   logic  m_push, m_pop;

   always #5 clk = ~clk;

   pipe_skid_stage dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .in_ctrl_i(in_ctrl_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o), .occupancy_o(occupancy_o),
      .flush_cnt_o(flush_cnt_o)
   );

   pipe_skid_stage #(.CNT_W(2)) u_sat (
      .clk_i(clk), .rst_i(rst_i), .flush_i(s_flush), .stall_i(1'b0),
      .in_valid_i(s_valid), .in_ready_o(s_in_ready), .in_data_i(s_data),
      .in_ctrl_i(4'h1), .out_valid_o(s_out_valid), .out_ready_i(1'b0),
      .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl), .occupancy_o(s_occ),
      .flush_cnt_o(s_fcnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c,
                        input logic ordy, input logic fl, input logic st);
      @(posedge clk);
      #1;
      in_valid_i  = v;
      in_data_i   = d;
      in_ctrl_i   = c;
      out_ready_i = ordy;
      flush_i     = fl;
      stall_i     = st;
   endtask

   // Reference model: the stage is a FIFO of depth two.
   always @(negedge clk) begin
      if (!rst_i) begin
         mdl_occ  = 0;
         exp_fcnt = 0;
         exp_q.delete();
      end else begin
         chk("occupancy", 64'(occupancy_o), 64'(mdl_occ));
         chk("in_ready", 64'(in_ready_o), 64'(mdl_occ < 2 && !stall_i));
         chk("out_valid", 64'(out_valid_o), 64'(mdl_occ > 0 && !stall_i));
         chk("flush_cnt", 64'(flush_cnt_o), 64'(exp_fcnt));
         if (!stall_i) begin
            if (flush_i) begin
               if (mdl_occ > 0 && exp_fcnt < 65535) exp_fcnt++;
               mdl_occ = 0;
               exp_q.delete();
            end else begin
               m_push = in_valid_i && (mdl_occ < 2);
               m_pop  = (mdl_occ > 0) && out_ready_i;
               if (m_push) exp_q.push_back(beat_t'{data: in_data_i, ctrl: in_ctrl_i});
               mdl_occ = mdl_occ + int'(m_push) - int'(m_pop);
            end
         end
      end
   end

   // Monitor: every beat the DUT hands downstream must match the queue head.
   always @(negedge clk) begin
      if (rst_i) begin
         if (!out_valid_o) begin
            chk("ctrl_bubble", 64'(out_ctrl_o), 64'(0));
         end else if (out_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_underflow: got 0x%0h expected no beat at %0t", out_data_o, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_data", 64'(out_data_o), 64'(mon_e.data));
               chk("out_ctrl", 64'(out_ctrl_o), 64'(mon_e.ctrl));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: got no finish expected finish by %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst_i = 1'b0;
      in_valid_i = 1'b0; in_data_i = '0; in_ctrl_i = '0;
      out_ready_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
      s_flush = 1'b0; s_valid = 1'b0; s_data = '0;
      #3;
      chk("rst_occ", 64'(occupancy_o), 64'(0));
      chk("rst_valid", 64'(out_valid_o), 64'(0));
      chk("rst_data", 64'(out_data_o), 64'(0));
      chk("rst_ctrl", 64'(out_ctrl_o), 64'(0));
      chk("rst_fcnt", 64'(flush_cnt_o), 64'(0));

      // Streaming at full throughput
      @(posedge clk); #1;
      rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h100; out_ready_i = 1'b1;
      #2 chk("stream_rdy", 64'(in_ready_o), 64'(1));
      drive(1, 32'h104, 4'h1, 1, 0, 0);
      #2 chk("stream_d0", 64'(out_data_o), 64'h100);
      chk("stream_occ0", 64'(occupancy_o), 64'(1));
      drive(1, 32'h108, 4'h2, 1, 0, 0);
      #2 chk("stream_d1", 64'(out_data_o), 64'h104);
      chk("stream_occ1", 64'(occupancy_o), 64'(1));
      drive(0, 32'h0, 4'h0, 1, 0, 0);
      #2 chk("stream_d2", 64'(out_data_o), 64'h108);
      drive(0, 32'h0, 4'h0, 1, 0, 0);
      #2 chk("stream_empty", 64'(occupancy_o), 64'(0));

      // Backpressure fills both entries, then drains in order
      drive(1, 32'hA, 4'h1, 0, 0, 0);
      drive(1, 32'hB, 4'h2, 0, 0, 0);
      drive(1, 32'hC, 4'h3, 0, 0, 0);
      #2 chk("bp_rdy", 64'(in_ready_o), 64'(0));
      chk("bp_occ", 64'(occupancy_o), 64'(2));
      chk("bp_head", 64'(out_data_o), 64'hA);
      drive(1, 32'hC, 4'h3, 1, 0, 0);
      drive(1, 32'hC, 4'h3, 1, 0, 0);
      #2 chk("bp_second", 64'(out_data_o), 64'hB);
      drive(0, 32'h0, 4'h0, 1, 0, 0);
      #2 chk("bp_third", 64'(out_data_o), 64'hC);
      drive(0, 32'h0, 4'h0, 1, 0, 0);

      // Flush of a full stage, then a flush while empty
      drive(1, 32'h1, 4'hF, 0, 0, 0);
      drive(1, 32'h2, 4'hF, 0, 0, 0);
      drive(0, 32'h0, 4'h0, 0, 1, 0);
      #2 chk("fl_pre_occ", 64'(occupancy_o), 64'(2));
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      #2 chk("fl_occ", 64'(occupancy_o), 64'(0));
      chk("fl_valid", 64'(out_valid_o), 64'(0));
      chk("fl_ctrl", 64'(out_ctrl_o), 64'(0));
      chk("fl_cnt", 64'(flush_cnt_o), 64'(1));
      drive(0, 32'h0, 4'h0, 0, 1, 0);
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      #2 chk("fl_cnt_empty", 64'(flush_cnt_o), 64'(1));

      // Stall overrides flush
      drive(1, 32'h55, 4'h5, 0, 0, 0);
      drive(1, 32'h66, 4'h6, 1, 1, 1);
      #2 chk("st_rdy", 64'(in_ready_o), 64'(0));
      chk("st_valid", 64'(out_valid_o), 64'(0));
      drive(1, 32'h66, 4'h6, 1, 1, 1);
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      #2 chk("st_occ", 64'(occupancy_o), 64'(1));
      chk("st_data", 64'(out_data_o), 64'h55);
      chk("st_fcnt", 64'(flush_cnt_o), 64'(1));
      drive(0, 32'h0, 4'h0, 1, 0, 0);
      drive(0, 32'h0, 4'h0, 0, 0, 0);

      // Asynchronous reset between edges
      drive(1, 32'h77, 4'h7, 0, 0, 0);
      drive(1, 32'h88, 4'h8, 0, 0, 0);
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      #1 rst_i = 1'b0;
      #1;
      chk("arst_occ", 64'(occupancy_o), 64'(0));
      chk("arst_valid", 64'(out_valid_o), 64'(0));
      chk("arst_data", 64'(out_data_o), 64'(0));
      chk("arst_ctrl", 64'(out_ctrl_o), 64'(0));
      chk("arst_fcnt", 64'(flush_cnt_o), 64'(0));
      @(posedge clk); #1 rst_i = 1'b1;

      // Randomised traffic with occasional flush and stall
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < 4; i++) drive(0, 32'h0, 4'h0, 1, 0, 0);

      // Flush counter saturation on the narrow-counter instance
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1 s_valid = 1'b1; s_data = 32'(k);
         @(posedge clk); #1 s_valid = 1'b0; s_flush = 1'b1;
         @(posedge clk); #1 s_flush = 1'b0;
         #2 chk("sat_cnt", 64'(s_fcnt), 64'((k < 3) ? k : 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
